memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 195 +++++++++++++++++++
 tb/tb_memory_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder
//
// Purpose:
//    Single-port word memory that answers CPU requests with a fixed,
//    programmable latency. A request is captured in IDLE. The FSM then
//    waits WAIT_STATES cycles and performs the access on the edge that
//    enters ACK. It holds ack for one cycle and returns to IDLE.
//
// Ports:
//    clock_i     sole clock, all state changes on the rising edge
//    reset_i     asynchronous, active-high reset (storage is not cleared)
//    req_i       request strobe, only looked at while idle
//    write_en_i  1 = write, 0 = read, sampled together with req_i
//    address_i   17-bit word address, bit 15 is the MSB
//    data_in_i   32-bit write data, bit 0 is the MSB
//    data_out_o  32-bit registered read data, changes only on a read access
//    ack_o       one-cycle completion pulse
//    busy_o      high whenever the FSM is not idle (registered)
//
// Parameters:
//    WAIT_STATES   extra cycles between capture and ack (0..15)
//    DEPTH         number of 32-bit words (power of two, <= 65536)
//    ADDRESS_MASK  mask applied to the word address before indexing

module memory_responder #(
   parameter int unsigned WAIT_STATES  = 2,
   parameter int unsigned DEPTH        = 128,
   parameter logic [16:0] ADDRESS_MASK = 17'h7f
) (
   input  logic         clock_i,
   input  logic         reset_i,
   input  logic         req_i,
   input  logic         write_en_i,
   input  logic [15:31] address_i,
   input  logic [0:31]  data_in_i,
   output logic [0:31]  data_out_o,
   output logic         ack_o,
   output logic         busy_o
);

   localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   // ------------------------------------------------------------------
   // State and latched request
   // ------------------------------------------------------------------
   logic [1:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             we_q, we_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             busy_q;
   logic             ack_q;
   logic [31:0]      dout_q;

   // Storage powers up zeroed and is deliberately left out of the reset
   // network, so an aborted or reset transaction never disturbs it.
   logic [31:0]      mem [DEPTH] = '{default: 32'h0};

   // Access strobe and operands for the memory port. They normally come
   // from the latched request. With zero wait states the capturing edge
   // is also the edge entering ACK, so the operands come straight from
   // the inputs being captured on that edge.
   logic             acc_go;
   logic             acc_we;
   logic [IDX_W-1:0] acc_idx;
   logic [31:0]      acc_wdata;

   // Out-of-mask address bits alias onto the same word instead of faulting.
   logic [16:0]      masked_addr;
   logic [IDX_W-1:0] in_idx;

   assign masked_addr = address_i & ADDRESS_MASK;
   assign in_idx      = masked_addr[IDX_W-1:0];

   generate
      if (IDX_W < 17) begin : g_addr_tail
         // Bits above the storage index only matter through the mask.
         logic unused_addr_bits;
         assign unused_addr_bits = ^masked_addr[16:IDX_W];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      acc_go    = 1'b0;
      acc_we    = we_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               idx_d   = in_idx;
               we_d    = write_en_i;
               wdata_d = data_in_i;
               cnt_d   = WAIT_INIT;
               if (WAIT_INIT == 4'd0) begin
                  state_d   = ST_ACK;
                  acc_go    = 1'b1;
                  acc_we    = write_en_i;
                  acc_idx   = in_idx;
                  acc_wdata = data_in_i;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end

         ST_WAIT: begin
            // The access fires on the edge where the counter reaches zero.
            // Treating zero like one keeps the FSM from looping if the
            // counter is ever found at zero here.
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = ST_ACK;
               acc_go  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         ST_ACK: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Control registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= 32'h0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         // busy and ack are decoded from the next state so both come
         // straight out of flops.
         busy_q  <= (state_d != ST_IDLE);
         ack_q   <= (state_d == ST_ACK);
      end
   end

   // ------------------------------------------------------------------
   // Memory write port
   // ------------------------------------------------------------------
   always_ff @(posedge clock_i) begin
      if (acc_go && acc_we) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   // ------------------------------------------------------------------
   // Registered read port
   // This register only loads on a read access, so data_out holds
   // through writes and idle cycles.
   // ------------------------------------------------------------------
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         dout_q <= 32'h0;
      end else if (acc_go && !acc_we) begin
         dout_q <= mem[acc_idx];
      end
   end

   assign data_out_o = dout_q;
   assign ack_o      = ack_q;
   assign busy_o     = busy_q;

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // DUT with the default two wait states
   logic        req_a, we_a, ack_a, busy_a;
   logic [16:0] addr_a;
   logic [31:0] din_a, dout_a;

   // DUT with zero wait states
   logic        req_z, we_z, ack_z, busy_z;
   logic [16:0] addr_z;
   logic [31:0] din_z, dout_z;

   memory_responder #(.WAIT_STATES(2)) dut_a (
      .clock_i    (clk),
      .reset_i    (rst),
      .req_i      (req_a),
      .write_en_i (we_a),
      .address_i  (addr_a),
      .data_in_i  (din_a),
      .data_out_o (dout_a),
      .ack_o      (ack_a),
      .busy_o     (busy_a)
   );

   memory_responder #(.WAIT_STATES(0)) dut_z (
      .clock_i    (clk),
      .reset_i    (rst),
      .req_i      (req_z),
      .write_en_i (we_z),
      .address_i  (addr_z),
      .data_in_i  (din_z),
      .data_out_o (dout_z),
      .ack_o      (ack_z),
      .busy_o     (busy_z)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model for dut_a: a plain word array indexed by the masked
   // address, plus the last value returned by a read.
   logic [31:0] model_mem [128];
   logic [31:0] last_read_a;

   typedef struct {
      logic        we;
      logic [16:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_dout;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // One transaction on dut_a, started at the current time (away from the
   // rising edge). If scramble is set, every input is randomised while the
   // DUT is busy.
   task automatic txn_a(input logic we, input logic [16:0] addr, input logic [31:0] wd,
                        input bit scramble, input string tag);
      int lat = 0;
      int idx;
      idx    = int'(addr & 17'h7f);
      req_a  = 1'b1;
      we_a   = we;
      addr_a = addr;
      din_a  = wd;
      @(posedge clk); #1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         if (scramble) begin
            req_a  = 1'($urandom);
            we_a   = 1'($urandom);
            addr_a = 17'($urandom);
            din_a  = $urandom;
         end else begin
            req_a = 1'b0;
         end
         @(negedge clk);
         check({tag, " busy_during"}, 32'(busy_a), 32'd1);
         if (ack_a) begin
            lat = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      check({tag, " latency"}, lat, 32'd3);
      if (we) model_mem[idx] = wd;
      else    last_read_a    = model_mem[idx];
      check({tag, " data_out"}, dout_a, last_read_a);
      @(posedge clk); #1;
      req_a = 1'b0;
      we_a  = 1'b0;
      @(negedge clk);
      check({tag, " ack_single"}, 32'(ack_a), 32'd0);
      check({tag, " busy_after"}, 32'(busy_a), 32'd0);
      check({tag, " data_hold"}, dout_a, last_read_a);
      $display("txn %s we=%0b addr=%h wdata=%h data_out=%h latency=%0d",
               tag, we, addr, wd, dout_a, lat);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      logic [31:0] last_z;
      logic        prev_ack;

      for (int i = 0; i < 128; i++) model_mem[i] = 32'h0;
      last_read_a = 32'h0;

      vecs[0] = '{1'b1, 17'h00005, 32'hDEADBEEF, 32'h00000000};
      vecs[1] = '{1'b0, 17'h00005, 32'h00000000, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 17'h00085, 32'h12345678, 32'hDEADBEEF};
      vecs[3] = '{1'b0, 17'h00005, 32'h00000000, 32'h12345678};
      vecs[4] = '{1'b0, 17'h0007F, 32'h00000000, 32'h00000000};
      vecs[5] = '{1'b1, 17'h1FFFF, 32'hA5A5A5A5, 32'h00000000};
      vecs[6] = '{1'b0, 17'h0007F, 32'h00000000, 32'hA5A5A5A5};
      vecs[7] = '{1'b0, 17'h00085, 32'h00000000, 32'h12345678};

      rst = 1'b1;
      req_a = 0; we_a = 0; addr_a = 0; din_a = 0;
      req_z = 0; we_z = 0; addr_z = 0; din_z = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset ack_a", 32'(ack_a), 32'd0);
      check("reset busy_a", 32'(busy_a), 32'd0);
      check("reset dout_a", dout_a, 32'h0);
      check("reset ack_z", 32'(ack_z), 32'd0);
      check("reset busy_z", 32'(busy_z), 32'd0);
      check("reset dout_z", dout_z, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Table of directed vectors. The first one is accepted on the first
      // edge after reset is released.
      for (int v = 0; v < 8; v++) begin
         txn_a(vecs[v].we, vecs[v].addr, vecs[v].wd, 1'b1, $sformatf("vec%0d", v));
         check($sformatf("vec%0d table_dout", v), dout_a, vecs[v].exp_dout);
      end

      // Zero wait states with req held high: a capture on every even edge,
      // alternating write/read to aliases of word 3.
      last_z   = 32'h0;
      prev_ack = 1'b0;
      for (int k = 0; k < 12; k++) begin
         req_z = 1'b1;
         if (k % 2 == 0) begin
            we_z   = ((k / 2) % 2 == 0);
            addr_z = 17'h3 + 17'(k) * 17'h80;
            din_z  = 32'hC0DE0000 + 32'(k);
         end else begin
            we_z   = 1'($urandom);
            addr_z = 17'($urandom);
            din_z  = $urandom;
         end
         @(posedge clk);
         @(negedge clk);
         check($sformatf("ws0 k%0d ack", k), 32'(ack_z), 32'(k % 2 == 0));
         check($sformatf("ws0 k%0d busy", k), 32'(busy_z), 32'(k % 2 == 0));
         check($sformatf("ws0 k%0d ack_consecutive", k), 32'(ack_z & prev_ack), 32'd0);
         if (k % 4 == 2) last_z = 32'hC0DE0000 + 32'(k - 2);
         check($sformatf("ws0 k%0d dout", k), dout_z, last_z);
         prev_ack = ack_z;
         $display("txn ws0 k=%0d ack=%0b busy=%0b data_out=%h", k, ack_z, busy_z, dout_z);
      end
      req_z = 1'b0;

      // Reset during the wait phase of a write aborts it.
      req_a = 1'b1; we_a = 1'b1; addr_a = 17'h10; din_a = 32'hFFFFFFFF;
      @(posedge clk); #1;
      req_a = 1'b0; we_a = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("abort c%0d ack", c), 32'(ack_a), 32'd0);
         check($sformatf("abort c%0d busy", c), 32'(busy_a), 32'd0);
         check($sformatf("abort c%0d dout", c), dout_a, 32'h0);
         @(posedge clk); #1;
      end
      rst = 1'b0;
      last_read_a = 32'h0;
      $display("txn abort write addr=00010 under reset");
      txn_a(1'b0, 17'h10, 32'h0, 1'b0, "abort_read");
      check("abort_read const", dout_a, 32'h0);

      // Randomised traffic against the reference model.
      for (int n = 0; n < 150; n++) begin
         logic [16:0] ra;
         ra = {10'($urandom), 7'($urandom_range(0, 15))};
         txn_a(1'($urandom), ra, $urandom, 1'($urandom), $sformatf("rnd%0d", n));
      end

      // Write, read back, then a quiet stretch with req low.
      txn_a(1'b1, 17'h2A, 32'h0BADF00D, 1'b0, "idle_wr");
      txn_a(1'b0, 17'h2A, 32'h0, 1'b0, "idle_rd");
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         req_a  = 1'b0;
         we_a   = 1'($urandom);
         addr_a = 17'($urandom);
         din_a  = $urandom;
         @(negedge clk);
         check($sformatf("idle c%0d dout", c), dout_a, 32'h0BADF00D);
         check($sformatf("idle c%0d ack", c), 32'(ack_a), 32'd0);
         check($sformatf("idle c%0d busy", c), 32'(busy_a), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
